demux5_deser: RTL and testbench

Serial-to-parallel 1:5 deserializer, the receive-side complement of the 5:1 selector mux. It steps a slot counter through 0..4 and drives that counter as a mux select. It samples one serial bit per slot into the matching bit position, then presents the assembled 5-bit word with a one-cycle valid pulse. It sits downstream of a mux5 whose select it drives, and collects lab data-path bits back into a parallel register.

---
 rtl/demux5_deser.sv | 45 ++++
 tb/tb_demux5_deser.sv | 125 ++++++++++++
 2 files changed

// File: rtl/demux5_deser.sv
// demux5_deser: 1:5 serial-to-parallel deserializer driving an upstream mux5 select
module demux5_deser (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       din,
  output logic [2:0] s_out,
  output logic       busy,
  output logic [4:0] q,
  output logic       valid
);
  typedef enum logic {IDLE, CAPTURE} state_t;
  state_t     state;
  logic [2:0] slot;
  logic [4:0] shadow;
  always_comb begin
    busy  = state == CAPTURE;
    s_out = busy ? slot : 3'd5;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      slot   <= 3'd0;
      shadow <= 5'd0;
      q      <= 5'd0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE) begin
        slot  <= 3'd0;
        state <= start ? CAPTURE : IDLE;
      end else begin
        shadow[slot] <= din;
        if (slot == 3'd4) begin
          q     <= {din, shadow[3:0]};
          valid <= 1'b1;
          slot  <= 3'd0;
          state <= start ? CAPTURE : IDLE;
        end else begin
          slot <= slot + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_demux5_deser.sv
// tb_demux5_deser: table, directed and randomized self-checking bench for demux5_deser
module tb_demux5_deser;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b1;
  logic       din = 1'b1;
  logic [2:0] s_out;
  logic       busy;
  logic [4:0] q;
  logic       valid;
  int n_chk = 0;
  int n_fail = 0;
  bit m_busy = 1'b0;
  bit m_bits[$];
  logic [4:0] m_q = 5'd0;
  bit m_valid = 1'b0;
  typedef struct {
    logic       r, s, d;
    logic [2:0] es;
    logic       eb;
    logic [4:0] eq;
    logic       ev;
  } vec_t;
  vec_t tbl[9];
  demux5_deser dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .s_out(s_out), .busy(busy), .q(q), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic d);
    reset = r;
    start = s;
    din = d;
    if (r) begin
      m_busy = 1'b0;
      m_bits.delete();
      m_q = 5'd0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (!m_busy) begin
        m_busy = s;
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == 5) begin
          foreach (m_bits[i]) m_q[i] = m_bits[i];
          m_valid = 1'b1;
          m_bits.delete();
          m_busy = s;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("model", {s_out, busy, q, valid},
        {m_busy ? 3'(m_bits.size()) : 3'd5, m_busy, m_q, m_valid});
  endtask
  initial begin
    logic [7:0]  dl;
    logic [10:0] vmask, bmask;
    logic [4:0]  q2;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 5'b00000, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'b00000, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 5'b00000, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 5'b00000, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 5'b00000, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 5'b01101, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 5'b01101, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].d);
      chk($sformatf("table[%0d]", i), {s_out, busy, q, valid},
          {tbl[i].es, tbl[i].eb, tbl[i].eq, tbl[i].ev});
    end
    dl = 8'b0001_0110;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, dl[s_out]);
    chk("loopback", {s_out, busy, q, valid}, {3'd5, 1'b0, 5'b10110, 1'b1});
    chk("idle_mux_y", {9'd0, dl[s_out]}, 10'd0);
    for (int c = 0; c < 11; c++) begin
      step(1'b0, 1'b1, 1'(c % 2));
      vmask[c] = valid;
      bmask[c] = busy;
      if (c == 10) q2 = q;
    end
    chk("b2b_valid", {1'b0, vmask[10:2]}, {1'b0, 9'b100001000});
    chk("b2b_busy", {1'b0, bmask[10:2]}, {1'b0, 9'b111111111});
    chk("b2b_q2", {5'd0, q2}, {5'd0, 5'b01010});
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'($urandom));
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("ignored_start", {s_out, busy, q, valid}, {3'd5, 1'b0, 5'b10011, 1'b1});
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("midframe_reset", {s_out, busy, q, valid}, {3'd5, 1'b0, 5'b00000, 1'b0});
    step(1'b0, 1'b0, 1'b1);
    chk("post_reset_idle", {s_out, busy, q, valid}, {3'd5, 1'b0, 5'b00000, 1'b0});
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("fresh_frame", {s_out, busy, q, valid}, {3'd5, 1'b0, 5'b01110, 1'b1});
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
